// File: rtl/pipeline_run_ctrl.sv
// Run controller for a pipeline core: holds the core in reset, lets it run until
// the halt PC is fetched (plus a drain window) or a cycle limit expires.
module pipeline_run_ctrl #(
    parameter int PC_W         = 32,
    parameter int CNT_W        = 16,
    parameter int RST_CYCLES   = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int MAX_CYCLES   = 1000
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic             clear,
    input  logic [PC_W-1:0]  halt_pc,
    input  logic [PC_W-1:0]  pc,
    input  logic             retire,
    output logic             core_rstN,
    output logic             core_en,
    output logic             dump_req,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count
);

    localparam int HOLD_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RST_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]   RUN_LIMIT  = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        RUN,
        DRAIN,
        DONE,
        TIMEOUT
    } stateT;

    stateT              stateReg;
    logic [HOLD_W-1:0]  holdCnt;
    logic [DRAIN_W-1:0] drainCnt;
    logic [CNT_W-1:0]   cycleInc;
    logic [CNT_W-1:0]   retireInc;
    logic               haltHit;

    // Saturating increments; the counters stick at all-ones instead of wrapping.
    assign cycleInc  = (cycle_count == '1) ? cycle_count : cycle_count + 1'b1;
    assign retireInc = (retire && (retire_count != '1)) ? retire_count + 1'b1 : retire_count;
    assign haltHit   = (pc == halt_pc);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stateReg     <= IDLE;
            holdCnt      <= '0;
            drainCnt     <= '0;
            core_rstN    <= 1'b0;
            core_en      <= 1'b0;
            dump_req     <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            cycle_count  <= '0;
            retire_count <= '0;
        end else begin
            dump_req <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (start) begin
                        stateReg     <= HOLD;
                        holdCnt      <= HOLD_LAST;
                        cycle_count  <= '0;
                        retire_count <= '0;
                    end
                end
                HOLD: begin
                    if (holdCnt == '0) begin
                        stateReg  <= RUN;
                        core_rstN <= 1'b1;
                        core_en   <= 1'b1;
                    end else begin
                        holdCnt <= holdCnt - 1'b1;
                    end
                end
                RUN: begin
                    cycle_count  <= cycleInc;
                    retire_count <= retireInc;
                    // A halt match on the last allowed cycle still counts as a clean finish.
                    if (haltHit) begin
                        stateReg <= DRAIN;
                        drainCnt <= DRAIN_LAST;
                    end else if (cycle_count == RUN_LIMIT) begin
                        stateReg <= TIMEOUT;
                        core_en  <= 1'b0;
                        timeout  <= 1'b1;
                    end
                end
                DRAIN: begin
                    cycle_count  <= cycleInc;
                    retire_count <= retireInc;
                    if (drainCnt == '0) begin
                        stateReg <= DONE;
                        core_en  <= 1'b0;
                        done     <= 1'b1;
                        dump_req <= 1'b1;
                    end else begin
                        drainCnt <= drainCnt - 1'b1;
                    end
                end
                DONE, TIMEOUT: begin
                    if (clear) begin
                        stateReg  <= IDLE;
                        core_rstN <= 1'b0;
                        done      <= 1'b0;
                        timeout   <= 1'b0;
                    end
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

endmodule
